nibble_serial_add_ctrl: RTL and testbench

Sequencer that performs WIDTH-bit additions by time-multiplexing a single 4-bit ripple-carry adder slice, one nibble per clock, least-significant nibble first. It latches operands on a valid/ready input handshake, carries the inter-nibble carry in a register, assembles the result, and presents it on a valid/ready output handshake. It sits between operand producers and result consumers wherever a full-width adder is too costly.

---
 rtl/adder_seq_pkg.sv | 13 +
 rtl/nibble_serial_add_ctrl_if.sv | 27 ++
 rtl/ripple_carry_adder_4bit.sv | 25 ++
 rtl/nibble_serial_add_ctrl.sv | 88 ++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_seq_pkg.sv
// Shared definitions for the nibble-serial adder sequencer:
// controller state encoding and adder slice width.
package adder_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_add_ctrl.
// The master drives operands and out_ready; the slave is the adder sequencer.
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy
    );

endinterface

// File: rtl/ripple_carry_adder_4bit.sv
// Combinational 4-bit ripple-carry adder slice; the only arithmetic the
// sequencer uses for the operand data path.
module ripple_carry_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit adder built from one 4-bit slice reused once per clock, LS nibble
// first, with valid/ready handshakes on operand and result sides.
module nibble_serial_add_ctrl
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    nibble_serial_add_ctrl_if.slave bus
);

    localparam int NIB    = WIDTH / NIBBLE_W;
    localparam int IDX_W  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int BASE_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic                carry;
    logic [BASE_W-1:0]   base;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;

    assign base = BASE_W'(idx) << NIBBLE_W / 2;

    ripple_carry_adder_4bit u_slice (
        .a    (a_q[base +: NIBBLE_W]),
        .b    (b_q[base +: NIBBLE_W]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign bus.in_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            a_q           <= '0;
            b_q           <= '0;
            carry         <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_cout  <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q          <= bus.in_a;
                        b_q          <= bus.in_b;
                        carry        <= bus.in_cin;
                        idx          <= '0;
                        bus.out_sum  <= '0;
                        bus.out_cout <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    bus.out_sum[base +: NIBBLE_W] <= slice_sum;
                    carry                         <= slice_cout;
                    if (idx == LAST_IDX) begin
                        idx           <= '0;
                        bus.out_cout  <= slice_cout;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // Result stays frozen until the consumer takes it.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench: 16-bit and 4-bit builds, directed vectors with literal
// expectations plus a queue-based reference model checked every cycle.
module tb_nibble_serial_add_ctrl;

    localparam int W   = 16;
    localparam int NIB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nibble_serial_add_ctrl_if #(.WIDTH(16)) bus ();
    nibble_serial_add_ctrl_if #(.WIDTH(4))  bus4 ();

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted operand pair becomes one expected result,
    // visible NIB edges after acceptance and retired on the output handshake.
    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   retired = 0;

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + (W + 1)'(c);
    endfunction

    initial begin : compare
        bit           hs_in;
        bit           hs_out;
        bit           ev;
        logic [W-1:0] ca;
        logic [W-1:0] cb;
        logic         cc;
        logic [W:0]   r;
        forever begin
            @(negedge clk);
            hs_in  = 1'b0;
            hs_out = 1'b0;
            if (!rst_n) begin
                q.delete();
            end else begin
                ev = (q.size() > 0) && ((cyc - q[0].acc) >= NIB);
                check("in_ready", bus.in_ready, q.size() == 0);
                check("busy", bus.busy, q.size() != 0);
                check("out_valid", bus.out_valid, ev);
                if (ev) begin
                    check("out_sum", bus.out_sum, q[0].sum);
                    check("out_cout", bus.out_cout, q[0].cout);
                end
                hs_in  = bus.in_valid && (q.size() == 0);
                hs_out = ev && bus.out_ready;
                ca = bus.in_a;
                cb = bus.in_b;
                cc = bus.in_cin;
            end
            @(posedge clk);
            cyc++;
            if (rst_n) begin
                if (hs_out) begin
                    void'(q.pop_front());
                    retired++;
                end
                if (hs_in) begin
                    r = ref_add(ca, cb, cc);
                    q.push_back('{sum: r[W-1:0], cout: r[W], acc: cyc});
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        bit ok = 1'b0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = c;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            check("send_timeout", 0, 1);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] es, input logic ec, input int stall, input bit poke);
        int n = 0;
        send(a, b, c);
        while (!bus.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, NIB);
        check("sum_lit", bus.out_sum, es);
        check("cout_lit", bus.out_cout, ec);
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                bus.in_valid = 1'b1;
                bus.in_a     = 16'hDEAD;
                bus.in_b     = 16'hBEEF;
            end
            @(posedge clk);
            #1;
            check("in_ready_stall", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        check("sum_hold", bus.out_sum, es);
        check("cout_hold", bus.out_cout, ec);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("valid_drop", bus.out_valid, 0);
        check("in_ready_back", bus.in_ready, 1);
    endtask

    task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic c,
                          input logic [3:0] es, input logic ec);
        int n = 0;
        bit ok = 1'b0;
        bus4.in_a     = a;
        bus4.in_b     = b;
        bus4.in_cin   = c;
        bus4.in_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus4.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("w4_accept", ok, 1);
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        while (!bus4.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("w4_latency", n, 1);
        check("w4_sum", bus4.out_sum, es);
        check("w4_cout", bus4.out_cout, ec);
        bus4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus4.out_ready = 1'b0;
        check("w4_valid_drop", bus4.out_valid, 0);
        check("w4_in_ready", bus4.in_ready, 1);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit soak_done = 1'b0;
        int start_retired;
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.in_cin     = 1'b0;
        bus.out_ready  = 1'b0;
        bus4.in_valid  = 1'b0;
        bus4.in_a      = '0;
        bus4.in_b      = '0;
        bus4.in_cin    = 1'b0;
        bus4.out_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_out_cout", bus.out_cout, 0);
        check("rst_w4_in_ready", bus4.in_ready, 1);
        check("rst_w4_out_valid", bus4.out_valid, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // out_ready while idle must not disturb anything.
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        do_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0, 1'b0);
        do_op(16'h5A5A, 16'hA5A5, 1'b1, 16'h0000, 1'b1, 0, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1, 1'b0);
        do_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 0, 1'b0);
        do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 10, 1'b1);

        // Async reset two nibbles into a run.
        send(16'h1234, 16'h1111, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_in_ready", bus.in_ready, 1);
        check("midrun_out_valid", bus.out_valid, 0);
        check("midrun_busy", bus.busy, 0);
        check("midrun_out_sum", bus.out_sum, 0);
        check("midrun_out_cout", bus.out_cout, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 0, 1'b0);

        do_op4(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);
        do_op4(4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1);
        do_op4(4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0);

        // Back-to-back random soak with random consumer stalls.
        start_retired = retired;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    send(16'($urandom), 16'($urandom), 1'($urandom));
                end
                soak_done = 1'b1;
            end
            begin
                for (int t = 0; t < 40000; t++) begin
                    if (soak_done && q.size() == 0) break;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b0;
            end
        join
        check("soak_retired", retired - start_retired, 1000);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
